// File: rtl/seq_pkg.sv
// Shared encodings and sizing constants for the phase sequencer.
package seq_pkg;

    localparam int unsigned PHASE_W      = 3;
    localparam int unsigned WAIT_W       = 4;
    localparam int unsigned MEM_WAIT_DEF = 1;

    typedef enum logic [PHASE_W-1:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_HOLD   = 3'd6
    } seq_state_e;

endpackage

// File: rtl/cycle_sequencer_wait_timer.sv
// Loadable down-counter that times the dwell in the MEM phase.
module wait_timer
    import seq_pkg::*;
(
    input  logic              clock,
    input  logic              reset,
    input  logic              load,
    input  logic [WAIT_W-1:0] load_val,
    input  logic              dec,
    output logic              zero
);

    logic [WAIT_W-1:0] cnt_q;

    // Load takes priority; decrement stops at zero.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else if (load) begin
            cnt_q <= load_val;
        end else if (dec && (cnt_q != '0)) begin
            cnt_q <= cnt_q - 1'b1;
        end
    end

    assign zero = (cnt_q == '0);

endmodule

// File: rtl/cycle_sequencer.sv
// Single-clock phase sequencer: steps one instruction through
// fetch/decode/execute/mem/writeback with one-cycle enable strobes.
module cycle_sequencer
    import seq_pkg::*;
#(
    parameter int unsigned MEM_WAIT = MEM_WAIT_DEF,
    parameter int unsigned CNT_W    = 32
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               is_mem,
    input  logic               is_store,
    input  logic               rd_write,
    input  logic               hold,
    output logic               imem_en,
    output logic               ir_load,
    output logic               alu_en,
    output logic               dmem_en,
    output logic               dmem_wren,
    output logic               reg_we,
    output logic               pc_en,
    output logic [PHASE_W-1:0] phase,
    output logic               busy,
    output logic [CNT_W-1:0]   retired
);

    seq_state_e state;
    logic       rd_flag;
    logic       timer_load;
    logic       timer_dec;
    logic       timer_zero;

    // MEM dwell timer: armed when leaving EXEC for MEM, counts down in MEM.
    always_comb begin
        timer_load = (state == S_EXEC) && is_mem;
        timer_dec  = (state == S_MEM) && !timer_zero;
    end

    wait_timer u_wait_timer (
        .clock    (clock),
        .reset    (reset),
        .load     (timer_load),
        .load_val (WAIT_W'(MEM_WAIT)),
        .dec      (timer_dec),
        .zero     (timer_zero)
    );

    // Strobes are registered from the state being entered, so each one is
    // high exactly during the cycle its phase occupies.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state     <= S_IDLE;
            imem_en   <= 1'b0;
            ir_load   <= 1'b0;
            alu_en    <= 1'b0;
            dmem_en   <= 1'b0;
            dmem_wren <= 1'b0;
            reg_we    <= 1'b0;
            pc_en     <= 1'b0;
            busy      <= 1'b0;
            rd_flag   <= 1'b0;
            retired   <= '0;
        end else begin
            imem_en   <= 1'b0;
            ir_load   <= 1'b0;
            alu_en    <= 1'b0;
            dmem_en   <= 1'b0;
            dmem_wren <= 1'b0;
            reg_we    <= 1'b0;
            pc_en     <= 1'b0;
            busy      <= 1'b1;
            case (state)
                S_IDLE: begin
                    state   <= S_FETCH;
                    imem_en <= 1'b1;
                end
                S_FETCH: begin
                    state   <= S_DECODE;
                    ir_load <= 1'b1;
                end
                S_DECODE: begin
                    state  <= S_EXEC;
                    alu_en <= 1'b1;
                end
                S_EXEC: begin
                    rd_flag <= rd_write;
                    if (is_mem) begin
                        state     <= S_MEM;
                        dmem_en   <= 1'b1;
                        dmem_wren <= is_store;
                    end else begin
                        state  <= S_WB;
                        pc_en  <= 1'b1;
                        reg_we <= rd_write;
                    end
                end
                S_MEM: begin
                    if (timer_zero) begin
                        state  <= S_WB;
                        pc_en  <= 1'b1;
                        reg_we <= rd_flag;
                    end else begin
                        dmem_en <= 1'b1;
                    end
                end
                S_WB: begin
                    retired <= retired + CNT_W'(1);
                    if (hold) begin
                        state <= S_HOLD;
                        busy  <= 1'b0;
                    end else begin
                        state   <= S_FETCH;
                        imem_en <= 1'b1;
                    end
                end
                S_HOLD: begin
                    if (hold) begin
                        busy <= 1'b0;
                    end else begin
                        state   <= S_FETCH;
                        imem_en <= 1'b1;
                    end
                end
                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    assign phase = state;

endmodule

// File: tb/tb_cycle_sequencer.sv
// Directed bench for cycle_sequencer: two instances (MEM_WAIT=1/CNT_W=32
// and MEM_WAIT=3/CNT_W=4) stepped one clock at a time.
module tb_cycle_sequencer;

    // {phase[2:0], imem_en, ir_load, alu_en, dmem_en, dmem_wren, reg_we, pc_en, busy}
    localparam logic [10:0] P_IDLE   = 11'b000_00000000;
    localparam logic [10:0] P_FETCH  = 11'b001_10000001;
    localparam logic [10:0] P_DECODE = 11'b010_01000001;
    localparam logic [10:0] P_EXEC   = 11'b011_00100001;
    localparam logic [10:0] P_MEM_WR = 11'b100_00011001;
    localparam logic [10:0] P_MEM    = 11'b100_00010001;
    localparam logic [10:0] P_WB_WE  = 11'b101_00000111;
    localparam logic [10:0] P_WB     = 11'b101_00000011;
    localparam logic [10:0] P_HOLD   = 11'b110_00000000;

    logic        clock;
    logic        reset_a, is_mem_a, is_store_a, rd_write_a, hold_a;
    logic        imem_en_a, ir_load_a, alu_en_a, dmem_en_a, dmem_wren_a;
    logic        reg_we_a, pc_en_a, busy_a;
    logic [2:0]  phase_a;
    logic [31:0] retired_a;

    logic        reset_b, is_mem_b, is_store_b, rd_write_b, hold_b;
    logic        imem_en_b, ir_load_b, alu_en_b, dmem_en_b, dmem_wren_b;
    logic        reg_we_b, pc_en_b, busy_b;
    logic [2:0]  phase_b;
    logic [3:0]  retired_b;

    int checks;
    int errors;

    cycle_sequencer #(.MEM_WAIT(1), .CNT_W(32)) dut_a (
        .clock(clock), .reset(reset_a), .is_mem(is_mem_a), .is_store(is_store_a),
        .rd_write(rd_write_a), .hold(hold_a), .imem_en(imem_en_a), .ir_load(ir_load_a),
        .alu_en(alu_en_a), .dmem_en(dmem_en_a), .dmem_wren(dmem_wren_a), .reg_we(reg_we_a),
        .pc_en(pc_en_a), .phase(phase_a), .busy(busy_a), .retired(retired_a)
    );

    cycle_sequencer #(.MEM_WAIT(3), .CNT_W(4)) dut_b (
        .clock(clock), .reset(reset_b), .is_mem(is_mem_b), .is_store(is_store_b),
        .rd_write(rd_write_b), .hold(hold_b), .imem_en(imem_en_b), .ir_load(ir_load_b),
        .alu_en(alu_en_b), .dmem_en(dmem_en_b), .dmem_wren(dmem_wren_b), .reg_we(reg_we_b),
        .pc_en(pc_en_b), .phase(phase_b), .busy(busy_b), .retired(retired_b)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic [10:0] vec_a();
        return {phase_a, imem_en_a, ir_load_a, alu_en_a, dmem_en_a, dmem_wren_a,
                reg_we_a, pc_en_a, busy_a};
    endfunction

    function automatic logic [10:0] vec_b();
        return {phase_b, imem_en_b, ir_load_b, alu_en_b, dmem_en_b, dmem_wren_b,
                reg_we_b, pc_en_b, busy_b};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset_a = 1'b0; is_mem_a = 1'b0; is_store_a = 1'b0; rd_write_a = 1'b0; hold_a = 1'b0;
        reset_b = 1'b0; is_mem_b = 1'b0; is_store_b = 1'b0; rd_write_b = 1'b0; hold_b = 1'b0;

        // Reset state
        #3;
        check("rst_a_outs", 32'(vec_a()), 32'(P_IDLE));
        check("rst_a_retired", retired_a, 32'd0);
        check("rst_b_outs", 32'(vec_b()), 32'(P_IDLE));

        // add on dut_a
        @(negedge clock);
        reset_a = 1'b1;
        rd_write_a = 1'b1;
        #1;
        check("add_idle", 32'(vec_a()), 32'(P_IDLE));
        tick(); check("add_fetch", 32'(vec_a()), 32'(P_FETCH));
        tick(); check("add_decode", 32'(vec_a()), 32'(P_DECODE));
        tick(); check("add_exec", 32'(vec_a()), 32'(P_EXEC));
        tick(); check("add_wb", 32'(vec_a()), 32'(P_WB_WE));
        check("add_wb_retired", retired_a, 32'd0);
        tick(); check("add_next_fetch", 32'(vec_a()), 32'(P_FETCH));
        check("add_retired", retired_a, 32'd1);

        // sw, MEM_WAIT=1
        is_mem_a = 1'b1; is_store_a = 1'b1; rd_write_a = 1'b0;
        tick(); check("sw_decode", 32'(vec_a()), 32'(P_DECODE));
        tick(); check("sw_exec", 32'(vec_a()), 32'(P_EXEC));
        tick(); check("sw_mem1", 32'(vec_a()), 32'(P_MEM_WR));
        tick(); check("sw_mem2", 32'(vec_a()), 32'(P_MEM));
        tick(); check("sw_wb", 32'(vec_a()), 32'(P_WB));
        tick(); check("sw_fetch", 32'(vec_a()), 32'(P_FETCH));
        check("sw_retired", retired_a, 32'd2);

        // hold raised in EXEC, held 5 cycles
        is_mem_a = 1'b0; is_store_a = 1'b0; rd_write_a = 1'b1;
        tick(); check("hold_decode", 32'(vec_a()), 32'(P_DECODE));
        tick(); check("hold_exec", 32'(vec_a()), 32'(P_EXEC));
        hold_a = 1'b1;
        tick(); check("hold_wb", 32'(vec_a()), 32'(P_WB_WE));
        for (int i = 0; i < 4; i++) begin
            tick();
            check("hold_state", 32'(vec_a()), 32'(P_HOLD));
            check("hold_retired", retired_a, 32'd3);
        end
        hold_a = 1'b0;
        tick(); check("hold_release_fetch", 32'(vec_a()), 32'(P_FETCH));
        check("hold_release_retired", retired_a, 32'd3);

        // reset in first MEM cycle of a sw
        is_mem_a = 1'b1; is_store_a = 1'b1; rd_write_a = 1'b0;
        tick(); check("rstmem_decode", 32'(vec_a()), 32'(P_DECODE));
        tick(); check("rstmem_exec", 32'(vec_a()), 32'(P_EXEC));
        tick(); check("rstmem_mem1", 32'(vec_a()), 32'(P_MEM_WR));
        #2;
        reset_a = 1'b0;
        #1;
        check("rstmem_outs", 32'(vec_a()), 32'(P_IDLE));
        check("rstmem_retired", retired_a, 32'd0);
        #1;
        reset_a = 1'b1;
        #1;
        check("rstmem_idle", 32'(vec_a()), 32'(P_IDLE));
        tick(); check("rstmem_fetch", 32'(vec_a()), 32'(P_FETCH));
        tick(); check("rstmem_decode2", 32'(vec_a()), 32'(P_DECODE));

        // lw on dut_b, MEM_WAIT=3
        @(negedge clock);
        reset_b = 1'b1;
        is_mem_b = 1'b1; is_store_b = 1'b0; rd_write_b = 1'b1;
        #1;
        check("lw_idle", 32'(vec_b()), 32'(P_IDLE));
        tick(); check("lw_fetch", 32'(vec_b()), 32'(P_FETCH));
        tick(); check("lw_decode", 32'(vec_b()), 32'(P_DECODE));
        tick(); check("lw_exec", 32'(vec_b()), 32'(P_EXEC));
        for (int i = 0; i < 4; i++) begin
            tick();
            check("lw_mem", 32'(vec_b()), 32'(P_MEM));
        end
        tick(); check("lw_wb", 32'(vec_b()), 32'(P_WB_WE));
        tick(); check("lw_fetch2", 32'(vec_b()), 32'(P_FETCH));
        check("lw_retired", 32'(retired_b), 32'd1);

        // retired wrap with CNT_W=4
        #2;
        reset_b = 1'b0;
        #1;
        check("wrap_rst_retired", 32'(retired_b), 32'd0);
        reset_b = 1'b1;
        is_mem_b = 1'b0; is_store_b = 1'b0; rd_write_b = 1'b1;
        tick(); check("wrap_fetch", 32'(vec_b()), 32'(P_FETCH));
        for (int n = 1; n <= 17; n++) begin
            repeat (4) tick();
            check("wrap_retired", 32'(retired_b), 32'(n % 16));
            check("wrap_phase", 32'(phase_b), 32'd1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/cycle_sequencer.md
# cycle_sequencer

Single-clock phase sequencer for the 32-bit multi-cycle processor. It replaces the ripple clock-divider chain: imem, regfile, dmem and processor all run on `clock` and are gated by one-cycle enable strobes. Sits between the top-level wrapper and the processor/memory instances. It drives one instruction through fetch, decode, execute, optional memory access and writeback, and counts retired instructions.

## Interface
Parameters:
- `MEM_WAIT`, 1: extra cycles held in MEM for the synchronous dmem read (legal 1..15).
- `CNT_W`, 32: width of the retired-instruction counter.

Ports:
- `clock`  in  1  single system clock; all state is on its rising edge.
- `reset`  in  1  asynchronous, active-low reset (low = reset asserted).
- `is_mem`  in  1  decoded instruction is lw/sw; sampled in EXEC.
- `is_store`  in  1  decoded instruction is sw; sampled in EXEC.
- `rd_write`  in  1  decoded instruction writes the regfile; sampled in EXEC.
- `hold`  in  1  external halt request (debug/loader); honoured only at an instruction boundary.
- `imem_en`  out  1  imem address valid; capture on this edge.
- `ir_load`  out  1  latch `q_imem` into the instruction register.
- `alu_en`  out  1  latch the ALU result and branch decision.
- `dmem_en`  out  1  dmem access active.
- `dmem_wren`  out  1  dmem write strobe; one cycle only.
- `reg_we`  out  1  regfile write enable.
- `pc_en`  out  1  PC update.
- `phase`  out  3  current state encoding.
- `busy`  out  1  high in every state except HOLD and IDLE.
- `retired`  out  CNT_W  count of completed instructions.

## Operation
States (3-bit encoding): IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, HOLD=6.

Reset asserted (any time, asynchronously): state goes to IDLE, all strobes are 0, `retired`=0, and the wait counter is 0.

Transitions:
- IDLE -> FETCH unconditionally. Exactly one idle cycle follows reset release.
- FETCH: `imem_en`=1 -> DECODE.
- DECODE: `ir_load`=1 -> EXEC.
- EXEC: `alu_en`=1. Latch `is_mem`, `is_store` and `rd_write` into internal flags.
  - If `is_mem` -> MEM, wait counter loaded with `MEM_WAIT`.
  - Otherwise -> WB.
- MEM: `dmem_en`=1 every cycle in MEM.
  - `dmem_wren`=1 only in the first MEM cycle, and only if the store flag is set.
  - Counter decrements each cycle; at 0 -> WB.
  - Dwell in MEM is `MEM_WAIT`+1 cycles.
- WB: `pc_en`=1; `reg_we`=latched `rd_write`; `retired` increments.
  - If `hold` -> HOLD, else -> FETCH.
- HOLD: all strobes 0; stays while `hold`=1; -> FETCH on the first cycle `hold`=0.

Other rules:
- `hold` is ignored outside WB/HOLD. An in-flight instruction always completes.
- `retired` wraps from 2^CNT_W-1 to 0 silently.
- A store with `rd_write`=1 is a decoder error. The sequencer still obeys both flags and does not check.
- The strobes are one-hot, except `dmem_en` with `dmem_wren`, and `pc_en` with `reg_we`.

## Timing
- All outputs are registered (Moore decode of a registered state). There is no combinational path from any input to any output.
- Instruction latency:
  - ALU/branch: 4 cycles (FETCH, DECODE, EXEC, WB).
  - lw/sw: 5+`MEM_WAIT` cycles.
- First `imem_en` is the 2nd rising edge after `reset` goes high.
- Inputs `is_mem`, `is_store` and `rd_write` must be stable in EXEC only.
- `hold` is sampled at the end of the WB cycle and in each HOLD cycle.
- Reset asserted mid-MEM forces `dmem_wren` and `dmem_en` low immediately (asynchronously). No partial write is retried after reset.

## Structure
- Shared package `seq_pkg` holds:
  - the state encodings (`S_IDLE`..`S_HOLD`) and the phase width constant;
  - `MEM_WAIT` default and counter width (4 bits).
  The processor decode and testbench import it.
- One sub-module, `wait_timer`: a loadable 4-bit down-counter with a `zero` flag, used for MEM dwell.
- Everything else is a single next-state/output process in `cycle_sequencer`.

## Test plan
- Reset release, then an add (`is_mem`=0, `rd_write`=1):
  - IDLE, then `imem_en`, `ir_load`, `alu_en`, then `pc_en`+`reg_we` on cycles 2-5;
  - `retired`=1 after cycle 5.
- sw with `MEM_WAIT`=1:
  - MEM lasts 2 cycles;
  - `dmem_wren` high only in the first of them;
  - `reg_we`=0 in WB;
  - total 6 cycles.
- lw with `MEM_WAIT`=3:
  - `dmem_en` high for 4 cycles;
  - `dmem_wren` never high;
  - `reg_we`=1 in WB;
  - total 8 cycles.
- `hold` raised during EXEC and kept high 5 cycles:
  - instruction finishes WB, then HOLD with `busy`=0;
  - FETCH on the cycle after `hold` falls;
  - `retired` increments exactly once.
- Reset asserted in the first MEM cycle of a sw:
  - all outputs 0 in the same cycle;
  - `retired`=0;
  - restart at IDLE -> FETCH.
- `CNT_W`=4, run 17 ALU instructions: `retired` reads 15, then 0, then 1.
